// File: rtl/dct_odd_sched.sv
// dct_odd_sched
//   Issue scheduler for the shared odd-part shift-add unit of a row DCT.
//   Each row is fed to the unit as NGRP operand groups (passes). An issue
//   needs the row's operands (in_valid) and a free downstream
//   result-buffer entry (a credit). Issue tags are carried through a
//   LAT-deep shift register so that they line up with the unit's results.
//
//   Optional feature: define DCT_ODD_SCHED_ABORT_EN to add the abort input.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, n_rows   begin a block of n_rows rows (0 means 32), IDLE only
//   in_valid        current row's operands available
//   in_ready        current row consumed (last-group issue)
//   sa_issue        operands presented to the unit this cycle
//   sa_grp          operand-group select, valid with sa_issue
//   out_valid       unit result valid this cycle
//   out_row/out_grp row and group tag of the result
//   out_last        result is the last group of the last row
//   cred_ret        downstream freed one buffer entry
//   abort           (optional) stop issuing and drain
//   busy, done      not-IDLE / one-cycle end-of-block pulse
//   cred_err        sticky: credit returned while already full
//
// State table
//   IDLE  | waiting for start
//   RUN   | issuing groups while operands and credits allow
//   DRAIN | issuing finished, waiting for in-flight results
//   DONE  | one-cycle end-of-block pulse
module dct_odd_sched #(
    parameter  int LAT     = 3,
    parameter  int NGRP    = 2,
    parameter  int CREDITS = 4,
    localparam int GW      = (NGRP > 1) ? $clog2(NGRP) : 1,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    n_rows,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          sa_issue,
    output logic [GW-1:0] sa_grp,
    output logic          out_valid,
    output logic [4:0]    out_row,
    output logic [GW-1:0] out_grp,
    output logic          out_last,
    input  logic          cred_ret,
`ifdef DCT_ODD_SCHED_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic          cred_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

    state_t        state;
    logic [CW-1:0] credits;
    logic [4:0]    row;
    logic [4:0]    rows_m1;
    logic [GW-1:0] grp;

    logic [LAT-1:0] pipe_v;
    logic [LAT-1:0] pipe_last;
    logic [4:0]     pipe_row [LAT];
    logic [GW-1:0]  pipe_grp [LAT];

    logic abort_req;
    logic issue;
    logic last_grp;
    logic last_issue;
    logic in_flight;

`ifdef DCT_ODD_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // rst gates issue so a reset cycle never consumes a credit or
    // launches a tag.
    assign issue      = !rst && (state == RUN) && in_valid
                        && (credits != '0) && !abort_req;
    assign last_grp   = (grp == GRP_LAST);
    assign last_issue = issue && last_grp && (row == rows_m1);

    // Only stages that have not yet reached the output count as in flight;
    // the last stage is emerging this cycle, so DONE lands one cycle after it.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            in_flight = in_flight | pipe_v[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            rows_m1  <= '0;
            grp      <= '0;
            credits  <= CW'(CREDITS);
            cred_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        // n_rows=0 wraps to 31, i.e. a 32-row block.
                        rows_m1 <= 5'(n_rows - 6'd1);
                        row     <= '0;
                        grp     <= '0;
                    end
                end
                RUN: begin
                    if (abort_req || last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!in_flight) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (issue) begin
                if (last_grp) begin
                    grp <= '0;
                    row <= row + 5'd1;
                end else begin
                    grp <= grp + GW'(1);
                end
            end

            // issue only happens with credits>0, so no underflow path.
            if (issue && !cred_ret) begin
                credits <= credits - CW'(1);
            end else if (cred_ret && !issue) begin
                if (credits == CW'(CREDITS)) begin
                    cred_err <= 1'b1;
                end else begin
                    credits <= credits + CW'(1);
                end
            end
        end
    end

    // Tag pipeline: tags are zeroed on non-issue cycles so idle output
    // tags read as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v    <= '0;
            pipe_last <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_row[i] <= '0;
                pipe_grp[i] <= '0;
            end
        end else begin
            pipe_v[0]    <= issue;
            pipe_last[0] <= last_issue;
            pipe_row[0]  <= issue ? row : '0;
            pipe_grp[0]  <= issue ? grp : '0;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_row[i]  <= pipe_row[i-1];
                pipe_grp[i]  <= pipe_grp[i-1];
            end
        end
    end

    assign sa_issue  = issue;
    assign sa_grp    = grp;
    assign in_ready  = issue && last_grp;
    assign out_valid = pipe_v[LAT-1];
    assign out_last  = pipe_last[LAT-1];
    assign out_row   = pipe_row[LAT-1];
    assign out_grp   = pipe_grp[LAT-1];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: doc/dct_odd_sched.md
DCT_ODD_SCHED -- requirements
Module: dct_odd_sched

Interface
REQ-001 The block SHALL have parameter LAT, default 3, meaning the fixed pipeline latency in cycles of the shared odd-part shift-add unit.
REQ-002 The block SHALL have parameter NGRP, default 2, meaning the number of operand groups (passes) per row through the unit.
REQ-003 The block SHALL have parameter CREDITS, default 4, meaning the number of downstream result-buffer entries.
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  begin a block; sampled only in IDLE.
REQ-007 n_rows  in  6  rows in the block, 1..32; value 0 is treated as 32; captured on accepted start.
REQ-008 in_valid  in  1  the current row's operands are available.
REQ-009 in_ready  out  1  the current row is consumed (pulse on the last-group issue).
REQ-010 sa_issue  out  1  operands are presented to the unit this cycle.
REQ-011 sa_grp  out  clog2(NGRP)  operand-group mux select, valid with sa_issue.
REQ-012 out_valid  out  1  unit result is valid this cycle.
REQ-013 out_row  out  5  row tag of the result.
REQ-014 out_grp  out  clog2(NGRP)  group tag of the result.
REQ-015 out_last  out  1  result is the last group of the last row.
REQ-016 cred_ret  in  1  downstream freed one buffer entry.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse in state DONE.
REQ-019 cred_err  out  1  sticky flag: credit overflow.

Function
REQ-020 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on start.
- RUN->DRAIN on the cycle the last group of the last row issues.
- DRAIN->DONE when no issue is in flight.
- DONE->IDLE unconditionally after one cycle.
REQ-021 Issue SHALL occur in RUN only, in a cycle where in_valid=1 and credits>0; each issue decrements credits by 1.
REQ-022 sa_grp SHALL step 0..NGRP-1 within a row; it wraps to 0 and the row counter increments after group NGRP-1.
REQ-023 in_ready SHALL equal sa_issue AND (sa_grp==NGRP-1); it is never high outside RUN.
REQ-024 Stall cycles (in_valid=0 or credits=0) SHALL hold sa_grp and the row counter and deassert sa_issue.
REQ-025 out_valid, out_row, out_grp and out_last SHALL equal sa_issue and its tags delayed exactly LAT cycles through a shift register, independent of stalls and of FSM state.
REQ-026 The credit counter SHALL be 0..CREDITS and SHALL change as follows:
- cred_ret alone increments it.
- issue and cred_ret in the same cycle leave it unchanged.
- cred_ret at CREDITS with no issue leaves it at CREDITS and sets cred_err.
REQ-027 Credits SHALL persist across blocks (they are not reloaded on start).
REQ-028 start in any non-IDLE state SHALL be ignored.
REQ-029 start and cred_ret in the same cycle SHALL both take effect.
REQ-030 n_rows=1 SHALL issue exactly NGRP groups; n_rows=0 SHALL issue 32*NGRP groups.
REQ-031 done SHALL assert exactly one cycle after out_valid with out_last.
REQ-032 Minimum start-to-done latency with no stalls SHALL be rows*NGRP+LAT+1 cycles.

Reset
REQ-033 On rst the block SHALL enter IDLE and apply these values:
- credits=CREDITS.
- Row counter, group counter, the delay pipeline and cred_err are cleared.
- All outputs are 0.
REQ-034 rst mid-block SHALL discard in-flight tags with no out_valid afterwards, and SHALL take priority over start, cred_ret and abort.

Configuration
REQ-035 Macro DCT_ODD_SCHED_ABORT_EN, when defined, SHALL add input abort (1 bit), with this behaviour in RUN:
- abort stops issue that cycle and moves the FSM to DRAIN.
- in-flight results still emerge, with out_last=0.
- DONE and done follow as normal.
REQ-036 When the macro is undefined, the abort port SHALL be absent and the behaviour SHALL be exactly REQ-020..REQ-032.

Verification
REQ-037 Test basic: n_rows=2, in_valid=1, cred_ret pulsed every issue -> sa_issue for 4 cycles, grp 0,1,0,1; out_valid cycles 4-7 after start with rows 0,0,1,1; out_last on the 4th result; done one cycle later.
REQ-038 Test credit stall: CREDITS=4, n_rows=4, no cred_ret -> exactly 4 issues, then sa_issue stays low; one cred_ret yields exactly one further issue.
REQ-039 Test input stall: in_valid low for 3 cycles mid-row at grp=1 -> sa_grp stays 1 and in_ready pulses only on the resumed issue.
REQ-040 Test simultaneous/edge events: cred_ret at credits=4 with no issue -> cred_err=1 and credits stays 4; start during RUN -> ignored; n_rows=0 -> 64 issues.
REQ-041 Test reset mid-RUN: rst after 3 issues -> no out_valid in the following LAT cycles; busy=0 and credits=4 after reset.
REQ-042 Test abort (macro defined): abort after row 1 -> no further issue, pending results emerge with out_last=0, and done pulses.
